// File: rtl/alu_rx_if.sv
// Byte-in / command-out bundle between uart_rx, the frame assembler and the ALU stage.
// The master drives the strobe, the byte and ready; the slave (assembler) drives the command.
interface alu_rx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 6
);
    logic                  i_rx_done;
    logic [DATA_WIDTH-1:0] i_rx_data;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_data_a;
    logic [DATA_WIDTH-1:0] o_data_b;
    logic [OP_WIDTH-1:0]   o_op;
    logic                  o_valid;
    logic                  o_drop;
    logic                  o_timeout;

    modport master (
        output i_rx_done, i_rx_data, i_ready,
        input  o_data_a, o_data_b, o_op, o_valid, o_drop, o_timeout
    );

    modport slave (
        input  i_rx_done, i_rx_data, i_ready,
        output o_data_a, o_data_b, o_op, o_valid, o_drop, o_timeout
    );
endinterface

// File: rtl/alu_rx_interface.sv
// Assembles A, B, opcode bytes from uart_rx into one valid/ready command for the ALU.
// An inter-byte timeout drops partial frames so a lost byte cannot misalign the stream.
module alu_rx_interface #(
    parameter int DATA_WIDTH     = 8,
    parameter int OP_WIDTH       = 6,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic     clk,
    input  logic     reset,
    alu_rx_if.slave  bus
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GET_B,
        S_GET_OP,
        S_VALID
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [OP_WIDTH-1:0]   op_q;
    logic                  valid_q;
    logic                  drop_q;
    logic                  to_q;
    logic                  tc;

    assign tc    = (cnt_q == TC);
    assign cnt_d = cnt_q + CW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            to_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (bus.i_rx_done) begin
                        a_q     <= bus.i_rx_data;
                        state_q <= S_GET_B;
                    end
                end
                S_GET_B: begin
                    // A strobe on the terminal count still wins over the timeout.
                    if (bus.i_rx_done) begin
                        b_q     <= bus.i_rx_data;
                        cnt_q   <= '0;
                        state_q <= S_GET_OP;
                    end else if (tc) begin
                        cnt_q   <= '0;
                        to_q    <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_GET_OP: begin
                    if (bus.i_rx_done) begin
                        op_q    <= bus.i_rx_data[OP_WIDTH-1:0];
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_VALID;
                    end else if (tc) begin
                        cnt_q   <= '0;
                        to_q    <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_VALID: begin
                    // Command is frozen; any byte here (even on the transfer edge) is lost.
                    cnt_q <= '0;
                    if (bus.i_rx_done) drop_q <= 1'b1;
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_data_a  = a_q;
    assign bus.o_data_b  = b_q;
    assign bus.o_op      = op_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_drop    = drop_q;
    assign bus.o_timeout = to_q;

endmodule

// File: tb/tb_alu_rx_interface.sv
// Frame-assembler bench: directed scenarios plus random byte streams, checked by a
// queue-based reference model and an independent negedge monitor.
module tb_alu_rx_interface;

    localparam int T = 1000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_rx_if #(.DATA_WIDTH(8), .OP_WIDTH(6)) bus ();

    alu_rx_interface #(.DATA_WIDTH(8), .OP_WIDTH(6), .TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        int         vcyc;
    } frame_t;

    frame_t     exp_q[$];
    int         drop_q[$];
    int         to_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] part[$];
    int         last = 0;
    bit         pend = 0;
    bit         vprev = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic fail(input string nm, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected none (cycle %0d)", nm, act, cyc);
    endtask

    // Reference model: bytes collect into a list; three bytes make a command; a
    // pending command absorbs bytes as drops; a gap of more than T cycles since the
    // last accepted byte of a partial frame discards it.
    task automatic step(input bit s, input logic [7:0] d, input bit r);
        int c;
        c = cyc;
        bus.i_rx_done = s;
        bus.i_rx_data = s ? d : 8'($urandom);
        bus.i_ready   = r;
        if (pend) begin
            if (r) pend = 0;
            if (s) drop_q.push_back(c + 1);
        end else if (s) begin
            part.push_back(d);
            last = c;
            if (part.size() == 3) begin
                frame_t f;
                f.a    = part[0];
                f.b    = part[1];
                f.op   = part[2][5:0];
                f.vcyc = c + 1;
                exp_q.push_back(f);
                part.delete();
                pend = 1;
            end
        end else if (part.size() != 0 && c - last == T) begin
            to_q.push_back(c + 1);
            part.delete();
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input bit r);
        repeat (n) step(1'b0, 8'h00, r);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o, input bit r);
        step(1'b1, a, r);
        idle(3, r);
        step(1'b1, b, r);
        idle(3, r);
        step(1'b1, o, r);
    endtask

    task automatic do_reset();
        bus.i_rx_done = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.o_valid), 0);
        chk("rst_drop", 32'(bus.o_drop), 0);
        chk("rst_timeout", 32'(bus.o_timeout), 0);
        chk("rst_a", 32'(bus.o_data_a), 0);
        chk("rst_b", 32'(bus.o_data_b), 0);
        chk("rst_op", 32'(bus.o_op), 0);
        part.delete();
        pend = 0;
        exp_q.delete();
        drop_q.delete();
        to_q.delete();
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    function automatic bit rr();
        return ($urandom_range(0, 3) != 0);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            vprev <= 1'b0;
        end else begin
            if (bus.o_drop && bus.o_timeout) fail("drop_and_timeout", 32'h3);
            if (bus.o_drop) begin
                if (drop_q.size() == 0) fail("drop_unexpected", 32'h1);
                else chk("drop_cycle", 32'(cyc), 32'(drop_q.pop_front()));
            end
            if (bus.o_timeout) begin
                if (to_q.size() == 0) fail("timeout_unexpected", 32'h1);
                else chk("timeout_cycle", 32'(cyc), 32'(to_q.pop_front()));
            end
            if (bus.o_valid) begin
                if (exp_q.size() == 0) begin
                    fail("valid_unexpected", 32'h1);
                end else begin
                    if (!vprev) chk("valid_rise_cycle", 32'(cyc), 32'(exp_q[0].vcyc));
                    chk("data_a", 32'(bus.o_data_a), 32'(exp_q[0].a));
                    chk("data_b", 32'(bus.o_data_b), 32'(exp_q[0].b));
                    chk("op", 32'(bus.o_op), 32'(exp_q[0].op));
                    if (bus.i_ready) void'(exp_q.pop_front());
                end
            end
            vprev <= bus.o_valid;
        end
    end

    initial begin
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = 8'h00;
        bus.i_ready   = 1'b0;
        #10;
        chk("init_valid", 32'(bus.o_valid), 0);
        chk("init_drop", 32'(bus.o_drop), 0);
        chk("init_timeout", 32'(bus.o_timeout), 0);
        chk("init_a", 32'(bus.o_data_a), 0);
        chk("init_b", 32'(bus.o_data_b), 0);
        chk("init_op", 32'(bus.o_op), 0);
        #10;
        reset = 1'b1;
        @(posedge clk);
        #2;

        // Quiet line: nothing may happen.
        idle(1000, 1'b0);
        chk("idle_valid", 32'(bus.o_valid), 0);
        chk("idle_a", 32'(bus.o_data_a), 0);
        chk("idle_op", 32'(bus.o_op), 0);

        // Widely spaced frame, consumer always ready.
        step(1'b1, 8'hD6, 1'b1);
        idle(600, 1'b1);
        step(1'b1, 8'h2A, 1'b1);
        idle(600, 1'b1);
        step(1'b1, 8'hE0, 1'b1);
        idle(5, 1'b1);
        chk("hold_valid_low", 32'(bus.o_valid), 0);
        chk("hold_a", 32'(bus.o_data_a), 32'hD6);
        chk("hold_b", 32'(bus.o_data_b), 32'h2A);
        chk("hold_op", 32'(bus.o_op), 32'h20);

        // Stalled consumer with a stray byte during the wait.
        frame(8'hD6, 8'h2A, 8'hE0, 1'b0);
        idle(200, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        idle(300, 1'b0);
        chk("stall_valid", 32'(bus.o_valid), 1);
        step(1'b0, 8'h00, 1'b1);
        chk("release_valid", 32'(bus.o_valid), 0);
        frame(8'h01, 8'h02, 8'h03, 1'b1);
        idle(5, 1'b1);

        // Timeout after two bytes, then a clean frame.
        step(1'b1, 8'h11, 1'b1);
        idle(3, 1'b1);
        step(1'b1, 8'h22, 1'b1);
        idle(T + 50, 1'b1);
        chk("to_no_valid", 32'(bus.o_valid), 0);
        frame(8'h33, 8'h44, 8'h05, 1'b1);
        idle(5, 1'b1);

        // Byte on the terminal count is accepted; one cycle later is not.
        step(1'b1, 8'hAA, 1'b1);
        idle(T - 1, 1'b1);
        step(1'b1, 8'hBB, 1'b1);
        idle(T - 1, 1'b1);
        step(1'b1, 8'hC7, 1'b1);
        idle(5, 1'b1);
        step(1'b1, 8'h10, 1'b1);
        idle(T, 1'b1);
        step(1'b1, 8'h20, 1'b1);
        step(1'b1, 8'h30, 1'b1);
        step(1'b1, 8'h3F, 1'b1);
        idle(5, 1'b1);

        // Asynchronous reset mid-frame and while a command is held.
        step(1'b1, 8'h77, 1'b1);
        idle(2, 1'b1);
        do_reset();
        frame(8'h81, 8'h82, 8'h83, 1'b0);
        idle(4, 1'b0);
        chk("pre_rst_valid", 32'(bus.o_valid), 1);
        do_reset();
        frame(8'h91, 8'h92, 8'h93, 1'b1);
        idle(5, 1'b1);

        // Random byte stream with random ready and occasional near-timeout gaps.
        for (int i = 0; i < 300; i++) begin
            int g;
            g = ($urandom_range(0, 19) == 0) ? int'($urandom_range(T - 3, T + 3))
                                             : int'($urandom_range(0, 6));
            repeat (g) step(1'b0, 8'h00, rr());
            step(1'b1, 8'($urandom), rr());
        end
        idle(20, 1'b1);

        chk("frames_left", 32'(exp_q.size()), 0);
        chk("drops_left", 32'(drop_q.size()), 0);
        chk("timeouts_left", 32'(to_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_rx_interface.md
Name: alu_rx_interface

Overview:
Frame assembler directly downstream of uart_rx. It consumes the one-cycle o_rx_done strobe and the received byte. It collects three consecutive bytes: operand A, operand B, then opcode. It presents them as one registered, valid/ready-handshaked command to the ALU stage. An inter-byte timeout discards partial frames so a lost byte cannot permanently misalign the byte stream.

Parameters:
DATA_WIDTH, 8, width of received byte and of each operand
OP_WIDTH, 6, opcode width; taken from the low OP_WIDTH bits of the third byte
TIMEOUT_CYCLES, 1_000_000, max clk cycles allowed between bytes of one frame (10 ms at 100 MHz)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
i_rx_done  in  1  one-cycle strobe from uart_rx: i_rx_data valid this cycle
i_rx_data  in  DATA_WIDTH  received byte from uart_rx
i_ready  in  1  downstream ALU stage accepts the command this cycle
o_data_a  out  DATA_WIDTH  operand A (first byte of frame)
o_data_b  out  DATA_WIDTH  operand B (second byte)
o_op  out  OP_WIDTH  opcode (third byte [OP_WIDTH-1:0])
o_valid  out  1  command complete and held stable until accepted
o_drop  out  1  one-cycle pulse: byte arrived while in S_VALID and was discarded
o_timeout  out  1  one-cycle pulse: partial frame discarded by timeout

Behaviour:
- Reset (reset=0, async): state S_IDLE; o_data_a, o_data_b, o_op = 0; o_valid, o_drop, o_timeout = 0; timeout counter = 0. Reset mid-frame or mid-handshake discards everything immediately.
- All outputs are registered. No combinational path from any input to any output.
- FSM states:
  - S_IDLE: on i_rx_done, capture i_rx_data into A reg and go to S_GET_B.
  - S_GET_B: on i_rx_done, capture into B reg and go to S_GET_OP.
  - S_GET_OP: on i_rx_done, capture i_rx_data[OP_WIDTH-1:0] into op reg, set o_valid=1, go to S_VALID. Upper byte bits are ignored.
  - S_VALID: o_valid=1; A, B and op are frozen. When i_ready=1, o_valid=0 on the next edge and the state returns to S_IDLE.
- Latency: o_valid rises on the clock edge following the cycle in which the opcode strobe is sampled (1 cycle).
- Handshake: transfer occurs on the edge where o_valid && i_ready.
  - i_ready while not valid is ignored.
  - o_data_a, o_data_b and o_op keep their last values after transfer until overwritten by the next frame.
- Drop rule: i_rx_done in S_VALID, including the transfer cycle itself, is discarded. o_drop pulses high for exactly one cycle on the next edge. The next frame starts only from a strobe seen in S_IDLE.
- Timeout:
  - The counter runs only in S_GET_B and S_GET_OP. It clears on every accepted byte and is held at 0 in S_IDLE and S_VALID.
  - When the counter reaches TIMEOUT_CYCLES-1 with no strobe: go to S_IDLE, pulse o_timeout for one cycle, clear the counter. A/B regs need not be cleared.
  - Simultaneous strobe and terminal count: the byte wins; it is accepted normally and there is no timeout.
  - Counter width is $clog2(TIMEOUT_CYCLES). No timeout applies in S_IDLE or S_VALID; S_VALID waits for i_ready indefinitely.
- Back-to-back frames: the minimum byte spacing from uart_rx far exceeds 2 cycles, so a new frame is never lost if i_ready is asserted within the byte time.
- o_drop and o_timeout are never high in the same cycle.

Test Plan:
1. Reset low 20 ns, release; no strobes -> all outputs 0, state idle for 1000 cycles.
2. Strobes with bytes 0xD6, 0x2A, 0xE0 spaced 52160 ns, i_ready=1 -> o_valid high exactly 1 cycle, starting the cycle after the third strobe; o_data_a=0xD6, o_data_b=0x2A, o_op=6'h20.
3. Same frame with i_ready=0 for 500 cycles, plus a 4th strobe 0x55 during the wait -> o_valid held, outputs unchanged, o_drop 1-cycle pulse. Raise i_ready -> o_valid falls next edge. A new frame 0x01, 0x02, 0x03 is then received correctly.
4. Send 0x11, 0x22, then nothing for TIMEOUT_CYCLES (override to 1000) -> o_timeout pulse at cycle 1000 after the 0x22 strobe, no o_valid. A following frame 0x33, 0x44, 0x05 gives A=0x33, B=0x44, op=0x05.
5. With TIMEOUT_CYCLES=1000, deliver byte B exactly at count 999 -> accepted, no o_timeout pulse, frame completes normally.
6. Assert reset after byte A and again while o_valid=1 -> outputs go to 0 asynchronously. A subsequent full frame is assembled from its first byte.
